mmu_loop_cnt: RTL and testbench

//   Parametrised nested-loop address counter for the MMU; successor of the single-step cnt.

---
 rtl/mmu_loop_cnt.sv | 188 ++++++++++++++++++
 tb/tb_mmu_loop_cnt.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mmu_loop_cnt.sv
// Nested-loop address counter: walks up to N_LOOP nested loops (loop 0 innermost),
// each with its own trip count and stride. It emits one address per accepted beat
// on a valid/ready stream, flags the final beat, and pulses done afterwards.
module mmu_loop_cnt #(
  parameter int unsigned DIM_ADDR = 12,
  parameter int unsigned DIM_STEP = 3,
  parameter int unsigned DIM_TRIP = 8,
  parameter int unsigned N_LOOP   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         start,
  input  logic [DIM_ADDR-1:0]          base,
  input  logic [N_LOOP*DIM_TRIP-1:0]   trip,
  input  logic [N_LOOP*DIM_STEP-1:0]   stride,
  input  logic                         mm_ss,
  input  logic                         ready,
  output logic                         valid,
  output logic [DIM_ADDR-1:0]          addr_o,
  output logic                         last,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic [DIM_ADDR-1:0] acc_q, acc_nxt;
  logic                mm_ss_q, mm_ss_nxt;
  logic [DIM_TRIP-1:0] tmax_q     [N_LOOP];
  logic [DIM_TRIP-1:0] tmax_nxt   [N_LOOP];
  logic [DIM_STEP-1:0] stride_q   [N_LOOP];
  logic [DIM_STEP-1:0] stride_nxt [N_LOOP];
  logic [DIM_TRIP-1:0] idx_q      [N_LOOP];
  logic [DIM_TRIP-1:0] idx_nxt    [N_LOOP];
  logic [DIM_ADDR-1:0] lvl_q      [N_LOOP];
  logic [DIM_ADDR-1:0] lvl_nxt    [N_LOOP];
  logic                valid_nxt, last_nxt, busy_nxt, done_nxt;
  logic [DIM_ADDR-1:0] addr_nxt;

  // Carry chain: sel marks the loop that advances, upd marks it and every loop below it
  logic [N_LOOP-1:0]   sel, upd;
  logic [DIM_ADDR-1:0] sum [N_LOOP];
  logic [DIM_ADDR-1:0] nxt;

  // One adder per loop; lowest non-saturated loop wins, selection resolved in one cycle
  always_comb begin : carry_chain
    logic lo_max;
    logic cov;
    lo_max = 1'b1;
    cov    = 1'b0;
    nxt    = '0;
    sel    = '0;
    upd    = '0;
    for (int k = 0; k < N_LOOP; k++) begin
      sum[k] = lvl_q[k] + DIM_ADDR'(stride_q[k]);
      sel[k] = lo_max & (idx_q[k] != tmax_q[k]);
      lo_max = lo_max & (idx_q[k] == tmax_q[k]);
      if (sel[k]) nxt = sum[k];
    end
    for (int k = N_LOOP - 1; k >= 0; k--) begin
      cov    = cov | sel[k];
      upd[k] = cov;
    end
  end

  // Next-state, datapath and registered-output values
  always_comb begin : next_logic
    logic all_max;
    state_nxt  = state_q;
    acc_nxt    = acc_q;
    mm_ss_nxt  = mm_ss_q;
    tmax_nxt   = tmax_q;
    stride_nxt = stride_q;
    idx_nxt    = idx_q;
    lvl_nxt    = lvl_q;
    valid_nxt  = valid;
    last_nxt   = last;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    all_max    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          acc_nxt   = base;
          mm_ss_nxt = mm_ss;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          for (int k = 0; k < N_LOOP; k++) begin
            // trip of 0 behaves as trip of 1, so the terminal index is 0 either way
            tmax_nxt[k]   = (trip[k*DIM_TRIP +: DIM_TRIP] == '0) ? '0
                            : trip[k*DIM_TRIP +: DIM_TRIP] - DIM_TRIP'(1);
            stride_nxt[k] = stride[k*DIM_STEP +: DIM_STEP];
            idx_nxt[k]    = '0;
            lvl_nxt[k]    = base;
            all_max       = all_max & (trip[k*DIM_TRIP +: DIM_TRIP] <= DIM_TRIP'(1));
          end
          last_nxt = all_max;
        end
      end
      S_RUN: begin
        if (valid && ready) begin
          if (last) begin
            state_nxt = S_DONE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            acc_nxt = nxt;
            for (int k = 0; k < N_LOOP; k++) begin
              if (sel[k])      idx_nxt[k] = idx_q[k] + DIM_TRIP'(1);
              else if (upd[k]) idx_nxt[k] = '0;
              if (upd[k])      lvl_nxt[k] = nxt;
              all_max = all_max & (idx_nxt[k] == tmax_q[k]);
            end
            last_nxt = all_max;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase

    // Word mode shifts only the presented address; acc keeps byte granularity
    addr_nxt = mm_ss_nxt ? (acc_nxt >> 2) : acc_nxt;
  end

  // State register; clr aborts exactly like reset
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q   <= '0;
      mm_ss_q <= 1'b0;
      valid   <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      addr_o  <= '0;
      for (int k = 0; k < N_LOOP; k++) begin
        tmax_q[k]   <= '0;
        stride_q[k] <= '0;
        idx_q[k]    <= '0;
        lvl_q[k]    <= '0;
      end
    end else begin
      acc_q   <= acc_nxt;
      mm_ss_q <= mm_ss_nxt;
      valid   <= valid_nxt;
      last    <= last_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      addr_o  <= addr_nxt;
      for (int k = 0; k < N_LOOP; k++) begin
        tmax_q[k]   <= tmax_nxt[k];
        stride_q[k] <= stride_nxt[k];
        idx_q[k]    <= idx_nxt[k];
        lvl_q[k]    <= lvl_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_mmu_loop_cnt.sv
// Directed bench for mmu_loop_cnt: hand-computed address sequences, stalls, wrap,
// word mode, abort and degenerate trip counts.
module tb_mmu_loop_cnt;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        start;
  logic [11:0] base;
  logic [23:0] trip;
  logic [8:0]  stride;
  logic        mm_ss;
  logic        ready;
  logic        valid;
  logic [11:0] addr_o;
  logic        last;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_q[$];
  int          stall_at  = -1;
  int          stall_len = 0;

  mmu_loop_cnt #(
    .DIM_ADDR(12), .DIM_STEP(3), .DIM_TRIP(8), .N_LOOP(3)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .base(base),
    .trip(trip), .stride(stride), .mm_ss(mm_ss), .ready(ready),
    .valid(valid), .addr_o(addr_o), .last(last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle; first beat is visible on return
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Check a whole walk against exp_q, optionally stalling (with a stray start) at one beat
  task automatic walk(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " valid"}, 32'(valid), 32'd1);
      chk({tag, " addr"},  32'(addr_o), 32'(exp_q[i]));
      chk({tag, " last"},  32'(last), (i == n - 1) ? 32'd1 : 32'd0);
      chk({tag, " busy"},  32'(busy), 32'd1);
      if (i == stall_at) begin
        ready = 1'b0;
        start = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          step();
          chk({tag, " stall valid"}, 32'(valid), 32'd1);
          chk({tag, " stall addr"},  32'(addr_o), 32'(exp_q[i]));
          chk({tag, " stall last"},  32'(last), (i == n - 1) ? 32'd1 : 32'd0);
        end
        ready = 1'b1;
        start = 1'b0;
      end
      step();
    end
    chk({tag, " end valid"}, 32'(valid), 32'd0);
    chk({tag, " done"},      32'(done), 32'd1);
    chk({tag, " end busy"},  32'(busy), 32'd0);
    step();
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    stall_at = -1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b0; base = '0; trip = '0; stride = '0;
    mm_ss = 1'b0; ready = 1'b1;
    step();
    step();
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst last",  32'(last),  32'd0);
    chk("rst busy",  32'(busy),  32'd0);
    chk("rst done",  32'(done),  32'd0);
    chk("rst addr",  32'(addr_o), 32'd0);
    rst = 1'b0;
    step();
    chk("idle valid", 32'(valid), 32'd0);

    // Innermost loop only
    base = 12'h010; trip = {8'd1, 8'd1, 8'd4}; stride = {3'd0, 3'd0, 3'd1};
    exp_q = '{12'h010, 12'h011, 12'h012, 12'h013};
    do_start();
    walk("w1");

    // Three nested loops, back-to-back start in the bubble after done
    base = 12'h000; trip = {8'd2, 8'd3, 8'd2}; stride = {3'd5, 3'd2, 3'd1};
    exp_q = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd5, 12'd6, 12'd7, 12'd8, 12'd9, 12'd10};
    do_start();
    walk("w2");

    // Same walk with a 3-cycle stall on beat 4 and start raised while busy
    stall_at = 4; stall_len = 3;
    do_start();
    walk("w3");

    // Wrap past the top of the address space; upper trips 0 act as 1
    base = 12'hFFE; trip = {8'd0, 8'd0, 8'd4}; stride = {3'd0, 3'd0, 3'd1};
    exp_q = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    do_start();
    walk("wrap");

    // Word mode
    base = 12'h020; trip = {8'd1, 8'd1, 8'd3}; stride = {3'd0, 3'd0, 3'd4}; mm_ss = 1'b1;
    exp_q = '{12'h008, 12'h009, 12'h00A};
    do_start();
    mm_ss = 1'b0;
    walk("word");

    // Abort on the second beat with a simultaneous start
    base = 12'h100; trip = {8'd1, 8'd1, 8'd4}; stride = {3'd0, 3'd0, 3'd2};
    do_start();
    chk("clr beat0", 32'(addr_o), 32'h100);
    step();
    chk("clr beat1", 32'(addr_o), 32'h102);
    clr = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; start = 1'b0;
    chk("clr valid", 32'(valid), 32'd0);
    chk("clr done",  32'(done),  32'd0);
    chk("clr busy",  32'(busy),  32'd0);
    chk("clr addr",  32'(addr_o), 32'd0);
    step();
    chk("clr idle valid", 32'(valid), 32'd0);
    chk("clr idle done",  32'(done),  32'd0);
    exp_q = '{12'h100, 12'h102, 12'h104, 12'h106};
    do_start();
    walk("restart");

    // All trips zero: one beat, immediately last; start in DONE is ignored
    base = 12'h055; trip = '0; stride = {3'd7, 3'd7, 3'd7};
    do_start();
    chk("t0 valid", 32'(valid), 32'd1);
    chk("t0 addr",  32'(addr_o), 32'h055);
    chk("t0 last",  32'(last), 32'd1);
    step();
    chk("t0 done", 32'(done), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t0 done start ignored", 32'(valid), 32'd0);
    chk("t0 done pulse", 32'(done), 32'd0);
    step();
    chk("t0 idle valid", 32'(valid), 32'd0);
    chk("t0 idle busy",  32'(busy),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
